ram_arb_2h: RTL and testbench
=============================

Name: ram_arb_2h

Overview:
Two-host arbiter and address decoder placed directly upstream of the single-port SRAM (ram_1p). It merges instruction-fetch (host 0) and data (host 1) request/grant/rvalid buses onto the RAM's single req/we/be/addr/wdata port. It routes the fixed one-cycle RAM response back to the owning host. Requests that fall outside the RAM window are terminated locally with an error response.

Parameters:
Depth, 128, RAM depth in 32-bit words; must match the RAM instance. Aw = $clog2(Depth).
BaseAddr, 32'h0010_0000, byte base address of the RAM window; aligned to Depth*4.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
h_req_i  in  2  per-host request; bit 0 = host 0, bit 1 = host 1
h_we_i  in  2  per-host write enable
h_be_i  in  2x4  per-host byte enables
h_addr_i  in  2x32  per-host byte address
h_wdata_i  in  2x32  per-host write data
h_gnt_o  out  2  per-host grant, combinational
h_rvalid_o  out  2  per-host response valid
h_rdata_o  out  2x32  per-host read data
h_err_o  out  2  per-host error, qualified by h_rvalid_o
ram_req_o  out  1  to RAM req_i
ram_we_o  out  1  to RAM we_i
ram_be_o  out  4  to RAM be_i
ram_addr_o  out  32  to RAM addr_i (offset from BaseAddr)
ram_wdata_o  out  32  to RAM wdata_i
ram_rvalid_i  in  1  from RAM rvalid_o
ram_rdata_i  in  32  from RAM rdata_o

Behaviour:
- Grant: at most one h_gnt_o bit is high per cycle, combinational from h_req_i and the priority pointer. A host whose req is low is never granted.
- Arbitration: round-robin. When exactly one host requests, that host is granted. When both request, the host not granted most recently wins.
- Priority pointer last_q updates on every grant. Reset value is 1, so host 0 wins the first conflict after reset.
- Decode: a request is in range iff BaseAddr <= addr < BaseAddr + Depth*4, checked on full 32 bits.
- In-range grant: ram_req_o = 1 in the same cycle. ram_we_o, ram_be_o and ram_wdata_o come from the granted host. ram_addr_o = addr - BaseAddr.
- Out-of-range grant: the request is still granted, but ram_req_o stays 0. An error response is queued.
- When ram_req_o = 0, the other ram_* outputs are driven to 0.
- Response tracking registers: pend_q, owner_q and err_q, all cleared on reset. On any grant they are set to 1, the granted host index, and !in_range respectively. Otherwise pend_q is cleared.
- Responses have a fixed latency of exactly 1 cycle after grant, so there is no backpressure.
- h_rvalid_o[h] = pend_q & (owner_q == h) & (err_q | ram_rvalid_i).
- h_err_o[h] = h_rvalid_o[h] & err_q.
- h_rdata_o of the owner = err_q ? 0 : ram_rdata_i. The non-owner's rdata is 0.
- Writes also receive an rvalid with no error. Host rdata for writes is don't-care and is passed through from the RAM.
- Back-to-back grants, including alternating hosts every cycle, sustain 1 request per cycle.
- Reset asserted mid-operation: pend_q is cleared and any in-flight response is dropped. All outputs return to 0 combinationally, except gnt, which follows req.
- Reset values of outputs: h_rvalid_o = 0, h_err_o = 0, h_rdata_o = 0. ram_req_o and h_gnt_o are combinational from inputs.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- When defined, the block adds output ports stat_gnt0_o [31:0], stat_gnt1_o [31:0] and stat_conflict_o [15:0]:
  - stat_gnt0_o / stat_gnt1_o count grants per host.
  - stat_conflict_o counts cycles with both requests high.
  - All counters saturate at all-ones, are cleared on reset, and are also cleared synchronously by an added input stat_clr_i. Clear wins over a simultaneous increment.
- When not defined, these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then host 0 reads addr 0x0010_0004 with RAM preloaded word[1] = 0xDEADBEEF -> h_gnt_o = 01 and ram_addr_o = 0x4 in the same cycle; next cycle h_rvalid_o[0] = 1, h_rdata_o[0] = 0xDEADBEEF, h_err_o = 0.
- Both hosts request in the first cycle after reset, held 4 cycles -> grants in order 0, 1, 0, 1; rvalids follow 1 cycle later to the matching owners.
- Host 1 writes be = 4'b0011, wdata = 0x12345678 to 0x0010_0008, then reads it back -> low halfword 0x5678 is updated and the upper bytes are unchanged; both responses have err = 0.
- Host 1 reads 0x0010_0200 (Depth = 128) -> granted with ram_req_o = 0; next cycle h_rvalid_o[1] = 1, h_err_o[1] = 1, h_rdata_o[1] = 0.
- Grant issued, then rst_ni pulsed low before the response cycle -> no h_rvalid_o after reset; the next conflict is won by host 0.
- With RAM_ARB_STATS_EN: 3 conflict cycles plus 2 solo host-1 grants -> stat_gnt0_o = 2, stat_gnt1_o = 3, stat_conflict_o = 3; asserting stat_clr_i together with a grant -> all counters read 0 in the next cycle.

Source files
------------

// File: rtl/ram_arb_2h.sv
// Two-host round-robin arbiter and address decoder in front of the single-port SRAM.
// Define RAM_ARB_STATS_EN to add saturating grant/conflict counters with a synchronous clear.
module ram_arb_2h #(
  parameter int unsigned Depth    = 128,
  parameter logic [31:0] BaseAddr = 32'h0010_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       h_req_i,
  input  logic [1:0]       h_we_i,
  input  logic [1:0][3:0]  h_be_i,
  input  logic [1:0][31:0] h_addr_i,
  input  logic [1:0][31:0] h_wdata_i,
  output logic [1:0]       h_gnt_o,
  output logic [1:0]       h_rvalid_o,
  output logic [1:0][31:0] h_rdata_o,
  output logic [1:0]       h_err_o,
  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [3:0]       ram_be_o,
  output logic [31:0]      ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic             ram_rvalid_i,
  input  logic [31:0]      ram_rdata_i
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic             stat_clr_i,
  output logic [31:0]      stat_gnt0_o,
  output logic [31:0]      stat_gnt1_o,
  output logic [15:0]      stat_conflict_o
`endif
);

  localparam logic [32:0] WindowBytes = 33'(Depth) * 33'd4;
  localparam logic [32:0] WindowLo    = {1'b0, BaseAddr};
  localparam logic [32:0] WindowHi    = WindowLo + WindowBytes;

  logic        last_q;
  logic        pend_q;
  logic        owner_q;
  logic        err_q;

  logic [1:0]  gnt;
  logic        any_gnt;
  logic        sel;
  logic [31:0] sel_addr;
  logic        in_range;
  logic        ram_go;
  logic        resp_ok;
  logic [31:0] resp_data;

  // last_q holds the most recent winner; on a conflict the other host goes first.
  always_comb begin
    gnt = 2'b00;
    case (h_req_i)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign any_gnt = |gnt;
  assign sel     = gnt[1];
  assign h_gnt_o = gnt;

  // 33-bit compare so a window touching the top of the address map cannot wrap.
  assign sel_addr = h_addr_i[sel];
  assign in_range = ({1'b0, sel_addr} >= WindowLo) && ({1'b0, sel_addr} < WindowHi);

  assign ram_go      = any_gnt & in_range & rst_ni;
  assign ram_req_o   = ram_go;
  assign ram_we_o    = ram_go & h_we_i[sel];
  assign ram_be_o    = ram_go ? h_be_i[sel]            : 4'h0;
  assign ram_addr_o  = ram_go ? (sel_addr - BaseAddr)  : 32'h0;
  assign ram_wdata_o = ram_go ? h_wdata_i[sel]         : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q  <= 1'b1;
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (any_gnt) begin
      last_q  <= sel;
      pend_q  <= 1'b1;
      owner_q <= sel;
      err_q   <= ~in_range;
    end else begin
      pend_q  <= 1'b0;
    end
  end

  // Out-of-range requests complete locally without waiting on the RAM.
  assign resp_ok   = pend_q & (err_q | ram_rvalid_i);
  assign resp_data = (pend_q & ~err_q) ? ram_rdata_i : 32'h0;

  assign h_rvalid_o[0] = resp_ok & ~owner_q;
  assign h_rvalid_o[1] = resp_ok &  owner_q;
  assign h_err_o       = h_rvalid_o & {2{err_q}};
  assign h_rdata_o[0]  = owner_q ? 32'h0 : resp_data;
  assign h_rdata_o[1]  = owner_q ? resp_data : 32'h0;

`ifdef RAM_ARB_STATS_EN
  logic [31:0] gnt0_cnt_q;
  logic [31:0] gnt1_cnt_q;
  logic [15:0] conflict_cnt_q;

  // Saturating counters; a clear beats any increment in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt0_cnt_q     <= '0;
      gnt1_cnt_q     <= '0;
      conflict_cnt_q <= '0;
    end else if (stat_clr_i) begin
      gnt0_cnt_q     <= '0;
      gnt1_cnt_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (gnt[0] && (gnt0_cnt_q != '1)) gnt0_cnt_q <= gnt0_cnt_q + 32'd1;
      if (gnt[1] && (gnt1_cnt_q != '1)) gnt1_cnt_q <= gnt1_cnt_q + 32'd1;
      if ((&h_req_i) && (conflict_cnt_q != '1)) conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign stat_gnt0_o     = gnt0_cnt_q;
  assign stat_gnt1_o     = gnt1_cnt_q;
  assign stat_conflict_o = conflict_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ram_arb_2h.sv
// Randomized scoreboard bench for ram_arb_2h with a behavioural SRAM and reference model.
// Stats checks are compiled in when RAM_ARB_STATS_EN is defined.
module tb_ram_arb_2h;

  localparam int unsigned Depth    = 128;
  localparam logic [31:0] BaseAddr = 32'h0010_0000;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [1:0]       h_req_i = '0;
  logic [1:0]       h_we_i = '0;
  logic [1:0][3:0]  h_be_i = '0;
  logic [1:0][31:0] h_addr_i = '0;
  logic [1:0][31:0] h_wdata_i = '0;
  logic [1:0]       h_gnt_o;
  logic [1:0]       h_rvalid_o;
  logic [1:0][31:0] h_rdata_o;
  logic [1:0]       h_err_o;
  logic             ram_req_o;
  logic             ram_we_o;
  logic [3:0]       ram_be_o;
  logic [31:0]      ram_addr_o;
  logic [31:0]      ram_wdata_o;
  logic             ram_rvalid_i = 1'b0;
  logic [31:0]      ram_rdata_i = '0;
`ifdef RAM_ARB_STATS_EN
  logic             stat_clr_i = 1'b0;
  logic [31:0]      stat_gnt0_o;
  logic [31:0]      stat_gnt1_o;
  logic [15:0]      stat_conflict_o;
`endif

  ram_arb_2h #(.Depth(Depth), .BaseAddr(BaseAddr)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .h_req_i      (h_req_i),
    .h_we_i       (h_we_i),
    .h_be_i       (h_be_i),
    .h_addr_i     (h_addr_i),
    .h_wdata_i    (h_wdata_i),
    .h_gnt_o      (h_gnt_o),
    .h_rvalid_o   (h_rvalid_o),
    .h_rdata_o    (h_rdata_o),
    .h_err_o      (h_err_o),
    .ram_req_o    (ram_req_o),
    .ram_we_o     (ram_we_o),
    .ram_be_o     (ram_be_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rvalid_i (ram_rvalid_i),
    .ram_rdata_i  (ram_rdata_i)
`ifdef RAM_ARB_STATS_EN
    ,
    .stat_clr_i      (stat_clr_i),
    .stat_gnt0_o     (stat_gnt0_o),
    .stat_gnt1_o     (stat_gnt1_o),
    .stat_conflict_o (stat_conflict_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural single-port SRAM with a fixed one-cycle read latency.
  logic [31:0] ram_mem [Depth];
  always @(posedge clk_i) begin
    ram_rvalid_i <= ram_req_o;
    if (ram_req_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[8:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        ram_rdata_i <= $urandom;
      end else begin
        ram_rdata_i <= ram_mem[ram_addr_o[8:2]];
      end
    end
  end

  typedef struct {
    int          host;
    bit          err;
    bit          is_read;
    logic [31:0] rdata;
    int          due;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] ref_mem [Depth];
  int          ref_last = 1;
  int          checks = 0;
  int          passed = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference model: predicts grant/RAM port at issue and queues the host response.
  task automatic checkOutput();
    int          win;
    logic [31:0] a;
    bit          inr;
    longint      off;
    resp_t       e;
    win = -1;
    if (h_req_i == 2'b11) win = (ref_last == 1) ? 0 : 1;
    else if (h_req_i[0])  win = 0;
    else if (h_req_i[1])  win = 1;
    check("gnt", h_gnt_o, (win < 0) ? 64'd0 : 64'(1 << win));
    if (win < 0) begin
      check("idle_ram", {ram_req_o, ram_we_o, ram_be_o, ram_addr_o}, 64'd0);
      return;
    end
    a   = h_addr_i[win];
    off = longint'(a) - longint'(BaseAddr);
    inr = (off >= 0) && (off < longint'(Depth) * 4);
    check("ram_req", ram_req_o, inr);
    if (inr) begin
      check("ram_addr", ram_addr_o, off);
      check("ram_ctrl", {ram_we_o, ram_be_o, ram_wdata_o}, {h_we_i[win], h_be_i[win], h_wdata_i[win]});
    end else begin
      check("oor_ram_zero", {ram_we_o, ram_be_o, ram_wdata_o, ram_addr_o}, 64'd0);
    end
    e.host    = win;
    e.err     = !inr;
    e.is_read = !h_we_i[win];
    e.rdata   = inr ? ref_mem[off / 4] : 32'h0;
    e.due     = cyc + 1;
    exp_q.push_back(e);
    if (inr && h_we_i[win])
      for (int b = 0; b < 4; b++)
        if (h_be_i[win][b]) ref_mem[off / 4][8*b +: 8] = h_wdata_i[win][8*b +: 8];
    ref_last = win;
  endtask

  // Drives one cycle of host traffic (called just after a rising edge).
  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] we,
                               input logic [1:0][3:0] be, input logic [1:0][31:0] addr,
                               input logic [1:0][31:0] wdata);
    h_req_i   = req;
    h_we_i    = we;
    h_be_i    = be;
    h_addr_i  = addr;
    h_wdata_i = wdata;
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input int host, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [1:0]       r;
    logic [1:0]       w;
    logic [1:0][3:0]  b;
    logic [1:0][31:0] a;
    logic [1:0][31:0] d;
    r = '0; w = '0; b = '0; a = '0; d = '0;
    r[host] = 1'b1; w[host] = we; b[host] = be; a[host] = addr; d[host] = wdata;
    applyStimulus(r, w, b, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 2'b00, '0, '0, '0);
  endtask

  task automatic doReset();
    rst_ni  = 1'b0;
    h_req_i = '0;
    exp_q.delete();
    ref_last = 1;
    @(negedge clk_i);
    check("reset_outputs", {h_rvalid_o, h_err_o, h_rdata_o[0]}, 64'd0);
    check("reset_rdata1", h_rdata_o[1], 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every DUT response must match the oldest queued expectation.
  always @(negedge clk_i) begin
    resp_t e;
    if (rst_ni) begin
      if (h_rvalid_o != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", h_rvalid_o, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid", h_rvalid_o, 64'(1 << e.host));
          check("err", h_err_o, e.err ? 64'(1 << e.host) : 64'd0);
          if (e.err || e.is_read) check("rdata", h_rdata_o[e.host], e.rdata);
          check("rdata_other", h_rdata_o[1 - e.host], 64'd0);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("missing_rvalid", h_rvalid_o, 64'(1 << e.host));
      end
    end
  end

  function automatic logic [31:0] pickAddr();
    case ($urandom_range(0, 9))
      0:       return BaseAddr - 32'd4;
      1:       return BaseAddr + Depth * 4;
      2:       return BaseAddr + Depth * 4 - 4;
      3:       return 32'hFFFF_FFFC;
      default: return BaseAddr + 4 * $urandom_range(0, Depth - 1);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < Depth; i++) begin
      ram_mem[i] = 32'hC000_0000 + i;
      ref_mem[i] = 32'hC000_0000 + i;
    end
    ram_mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
    ram_mem[2] = 32'hA5A5_A5A5; ref_mem[2] = 32'hA5A5_A5A5;

    @(posedge clk_i); #1;
    doReset();

    // Host 0 single read.
    issue(0, 1'b0, 4'hF, 32'h0010_0004, 32'h0);
    idle(1);

    // Conflict held four cycles straight out of reset.
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(2'b11, 2'b00, {4'hF, 4'hF},
                    {BaseAddr + 32'(8 * i + 4), BaseAddr + 32'(8 * i)}, '0);
    idle(1);

    // Partial write then read-back, followed by an out-of-range read.
    issue(1, 1'b1, 4'b0011, 32'h0010_0008, 32'h1234_5678);
    issue(1, 1'b0, 4'hF, 32'h0010_0008, 32'h0);
    idle(1);
    check("halfword_merge", ref_mem[2], 64'hA5A5_5678);
    issue(1, 1'b0, 4'hF, 32'h0010_0200, 32'h0);
    idle(1);

    // Reset lands between a grant and its response.
    issue(0, 1'b0, 4'hF, 32'h0010_0010, 32'h0);
    doReset();
    applyStimulus(2'b11, 2'b00, {4'hF, 4'hF}, {BaseAddr + 32'h20, BaseAddr + 32'h24}, '0);
    check("post_reset_winner", ref_last, 64'd0);
    idle(1);

    for (int i = 0; i < 300; i++)
      applyStimulus(2'($urandom), 2'($urandom), {4'($urandom), 4'($urandom)},
                    {pickAddr(), pickAddr()}, {32'($urandom), 32'($urandom)});
    idle(2);
    check("queue_drained", exp_q.size(), 64'd0);

`ifdef RAM_ARB_STATS_EN
    doReset();
    check("stats_reset", {stat_gnt0_o, stat_conflict_o}, 64'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b11, 2'b00, {4'hF, 4'hF}, {BaseAddr, BaseAddr + 32'h4}, '0);
    issue(1, 1'b0, 4'hF, BaseAddr + 32'h8, 32'h0);
    issue(1, 1'b0, 4'hF, BaseAddr + 32'hC, 32'h0);
    check("stat_gnt0", stat_gnt0_o, 64'd2);
    check("stat_gnt1", stat_gnt1_o, 64'd3);
    check("stat_conflict", stat_conflict_o, 64'd3);
    stat_clr_i = 1'b1;
    issue(0, 1'b0, 4'hF, BaseAddr, 32'h0);
    stat_clr_i = 1'b0;
    check("stat_clear", {stat_gnt0_o, stat_gnt1_o}, 64'd0);
    check("stat_clear_conflict", stat_conflict_o, 64'd0);
    idle(1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: bench did not complete, %0d/%0d so far", passed, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
